// File: rtl/hazard_if.sv
// Bundles the pipeline-side hazard signals seen by the hazard scoreboard.
// The pipeline drives the master side and the scoreboard is the slave.
interface hazard_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
);
  // FD-stage instruction
  logic [REG_BITS-1:0] fd_rs;
  logic [REG_BITS-1:0] fd_rt;
  logic                fd_rs_used;
  logic                fd_rt_used;
  logic                fd_is_md;

  // DX-stage instruction
  logic [REG_BITS-1:0] dx_rs;
  logic [REG_BITS-1:0] dx_rt;
  logic [REG_BITS-1:0] dx_rd;
  logic                dx_we;
  logic                dx_is_load;

  // Multicycle launch out of DX
  logic                md_start;
  logic [REG_BITS-1:0] md_rd;

  // Later-stage writers
  logic [REG_BITS-1:0] xm_rd;
  logic [REG_BITS-1:0] mw_rd;
  logic                xm_we;
  logic                mw_we;

  // Hazard unit results
  logic [1:0]          a_sel;
  logic [1:0]          b_sel;
  logic                stall;
  logic                md_busy;
  logic                md_overlap_err;
  logic [CNT_BITS-1:0] stall_count;

  modport master (
    output fd_rs, fd_rt, fd_rs_used, fd_rt_used, fd_is_md,
    output dx_rs, dx_rt, dx_rd, dx_we, dx_is_load,
    output md_start, md_rd,
    output xm_rd, mw_rd, xm_we, mw_we,
    input  a_sel, b_sel, stall, md_busy, md_overlap_err, stall_count
  );

  modport slave (
    input  fd_rs, fd_rt, fd_rs_used, fd_rt_used, fd_is_md,
    input  dx_rs, dx_rt, dx_rd, dx_we, dx_is_load,
    input  md_start, md_rd,
    input  xm_rd, mw_rd, xm_we, mw_we,
    output a_sel, b_sel, stall, md_busy, md_overlap_err, stall_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// DX operand forwarding selects, FD load-use / mult-div stall generation and a
// single-entry cycle-counting scoreboard for one in-flight multicycle operation.
module hazard_scoreboard #(
  parameter int REG_BITS   = 5,
  parameter int MD_LATENCY = 32,
  parameter int CNT_BITS   = 16
) (
  input  logic     clock,
  input  logic     reset,
  hazard_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_XM = 2'd1;
  localparam logic [1:0] SEL_MW = 2'd2;

  // The counter runs MD_LATENCY-1 down to 0, giving MD_LATENCY busy cycles.
  localparam logic [7:0] CNT_RELOAD = 8'(MD_LATENCY - 1);

  state_e                state_q, state_d;
  logic [REG_BITS-1:0]   pend_rd_q, pend_rd_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  overlap_q, overlap_d;
  logic [CNT_BITS-1:0]   stall_cnt_q, stall_cnt_d;

  logic                  load_use_stall;
  logic                  md_stall;
  logic                  stall;

  // XM is the younger producer, so it wins over MW; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_BITS-1:0] src,
    input logic [REG_BITS-1:0] xm_rd,
    input logic                xm_we,
    input logic [REG_BITS-1:0] mw_rd,
    input logic                mw_we
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (src != '0) begin
      if (xm_we && (xm_rd == src))      sel = SEL_XM;
      else if (mw_we && (mw_rd == src)) sel = SEL_MW;
    end
    return sel;
  endfunction

  assign bus.a_sel = fwd_sel(bus.dx_rs, bus.xm_rd, bus.xm_we, bus.mw_rd, bus.mw_we);
  assign bus.b_sel = fwd_sel(bus.dx_rt, bus.xm_rd, bus.xm_we, bus.mw_rd, bus.mw_we);

  assign load_use_stall = bus.dx_is_load && bus.dx_we && (bus.dx_rd != '0) &&
                          ((bus.fd_rs_used && (bus.fd_rs == bus.dx_rd)) ||
                           (bus.fd_rt_used && (bus.fd_rt == bus.dx_rd)));

  // Any new mult/div must wait behind the outstanding one, as must readers of its rd.
  assign md_stall = (state_q == S_BUSY) &&
                    (bus.fd_is_md ||
                     ((pend_rd_q != '0) &&
                      ((bus.fd_rs_used && (bus.fd_rs == pend_rd_q)) ||
                       (bus.fd_rt_used && (bus.fd_rt == pend_rd_q)))));

  assign stall = load_use_stall || md_stall;

  assign bus.stall          = stall;
  assign bus.md_busy        = (state_q == S_BUSY);
  assign bus.md_overlap_err = overlap_q;
  assign bus.stall_count    = stall_cnt_q;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    cnt_d     = cnt_q;
    overlap_d = overlap_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.md_start) begin
          state_d   = S_BUSY;
          pend_rd_d = bus.md_rd;
          cnt_d     = CNT_RELOAD;
        end
      end
      S_BUSY: begin
        if (cnt_q == 8'd0) begin
          if (bus.md_start) begin
            pend_rd_d = bus.md_rd;
            cnt_d     = CNT_RELOAD;
          end else begin
            state_d   = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (bus.md_start) overlap_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pend_rd_q   <= '0;
      cnt_q       <= '0;
      overlap_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_rd_q   <= pend_rd_d;
      cnt_q       <= cnt_d;
      overlap_q   <= overlap_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with MD_LATENCY=4, CNT_BITS=4.
module tb_hazard_scoreboard;

  localparam int REG_BITS   = 5;
  localparam int MD_LATENCY = 4;
  localparam int CNT_BITS   = 4;

  logic clock;
  logic reset;

  int checks = 0;
  int errors = 0;

  hazard_if #(.REG_BITS(REG_BITS), .CNT_BITS(CNT_BITS)) bus ();

  hazard_scoreboard #(
    .REG_BITS   (REG_BITS),
    .MD_LATENCY (MD_LATENCY),
    .CNT_BITS   (CNT_BITS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one edge; inputs changed afterwards are seen by the next edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fd_rs = '0; bus.fd_rt = '0; bus.fd_rs_used = 1'b0; bus.fd_rt_used = 1'b0;
    bus.fd_is_md = 1'b0;
    bus.dx_rs = '0; bus.dx_rt = '0; bus.dx_rd = '0; bus.dx_we = 1'b0; bus.dx_is_load = 1'b0;
    bus.md_start = 1'b0; bus.md_rd = '0;
    bus.xm_rd = '0; bus.mw_rd = '0; bus.xm_we = 1'b0; bus.mw_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_md_busy", 32'(bus.md_busy), 0);
    check("rst_overlap", 32'(bus.md_overlap_err), 0);
    check("rst_stall_count", 32'(bus.stall_count), 0);
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_a_sel", 32'(bus.a_sel), 0);

    // Forwarding priority and register 0 suppression
    bus.dx_rs = 5'd3; bus.xm_rd = 5'd3; bus.xm_we = 1'b1; bus.mw_rd = 5'd3; bus.mw_we = 1'b1;
    #1 check("fwd_xm_over_mw", 32'(bus.a_sel), 1);
    bus.xm_we = 1'b0;
    #1 check("fwd_mw", 32'(bus.a_sel), 2);
    bus.xm_we = 1'b1; bus.dx_rs = 5'd0; bus.xm_rd = 5'd0; bus.mw_rd = 5'd0;
    #1 check("fwd_r0_suppressed", 32'(bus.a_sel), 0);
    bus.dx_rt = 5'd9; bus.xm_rd = 5'd3; bus.mw_rd = 5'd9;
    #1 check("fwd_b_mw", 32'(bus.b_sel), 2);
    bus.xm_rd = 5'd9;
    #1 check("fwd_b_xm", 32'(bus.b_sel), 1);
    bus.mw_we = 1'b0; bus.xm_we = 1'b0;
    #1 check("fwd_b_none", 32'(bus.b_sel), 0);
    clear_inputs();

    // Load-use stall (combinational, no edge taken)
    bus.dx_is_load = 1'b1; bus.dx_we = 1'b1; bus.dx_rd = 5'd5; bus.fd_rt = 5'd5; bus.fd_rt_used = 1'b1;
    #1 check("lu_rt_stall", 32'(bus.stall), 1);
    bus.fd_rt_used = 1'b0;
    #1 check("lu_rt_unused", 32'(bus.stall), 0);
    bus.fd_rt_used = 1'b1; bus.dx_rd = 5'd0; bus.fd_rt = 5'd0;
    #1 check("lu_r0", 32'(bus.stall), 0);
    bus.dx_rd = 5'd5; bus.fd_rt_used = 1'b0; bus.fd_rs = 5'd5; bus.fd_rs_used = 1'b1;
    #1 check("lu_rs_stall", 32'(bus.stall), 1);
    bus.dx_is_load = 1'b0;
    #1 check("lu_not_load", 32'(bus.stall), 0);
    clear_inputs();
    #1;

    // MD latency: rd 7 held in FD stalls for exactly MD_LATENCY cycles
    do_reset();
    bus.md_start = 1'b1; bus.md_rd = 5'd7;
    #1 check("md_busy_before", 32'(bus.md_busy), 0);
    tick();
    bus.md_start = 1'b0; bus.fd_rs = 5'd7; bus.fd_rs_used = 1'b1;
    for (int i = 0; i < MD_LATENCY; i++) begin
      #1 check($sformatf("md_stall_c%0d", i), 32'(bus.stall), 1);
      tick();
    end
    check("md_stall_done", 32'(bus.stall), 0);
    check("md_busy_done", 32'(bus.md_busy), 0);
    check("md_stall_count", 32'(bus.stall_count), 4);
    clear_inputs();

    // Back-to-back accept on cnt==0, then an overlapping start at cnt==2
    do_reset();
    bus.md_start = 1'b1; bus.md_rd = 5'd4;
    tick();
    bus.md_start = 1'b0;
    for (int i = 0; i < 2 * MD_LATENCY; i++) begin
      check($sformatf("b2b_busy_c%0d", i), 32'(bus.md_busy), 1);
      check($sformatf("b2b_overlap_c%0d", i), 32'(bus.md_overlap_err), (i >= 6) ? 1 : 0);
      if (i == 1) begin
        bus.fd_is_md = 1'b1;
        #1 check("md_fd_is_md_stall", 32'(bus.stall), 1);
        bus.fd_is_md = 1'b0;
      end
      bus.md_start = (i == 3 || i == 5);
      bus.md_rd    = 5'd6;
      tick();
    end
    bus.md_start = 1'b0;
    #1;
    check("b2b_busy_end", 32'(bus.md_busy), 0);
    check("b2b_overlap_sticky", 32'(bus.md_overlap_err), 1);
    tick();
    tick();
    check("b2b_overlap_held", 32'(bus.md_overlap_err), 1);
    clear_inputs();

    // Reset mid-operation
    do_reset();
    check("rst_clears_overlap", 32'(bus.md_overlap_err), 0);
    bus.md_start = 1'b1; bus.md_rd = 5'd7;
    tick();
    bus.md_start = 1'b0; bus.fd_rs = 5'd7; bus.fd_rs_used = 1'b1;
    tick();
    tick();
    #1 check("midop_stall_before", 32'(bus.stall), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("midop_busy", 32'(bus.md_busy), 0);
    check("midop_stall", 32'(bus.stall), 0);
    check("midop_stall_count", 32'(bus.stall_count), 0);
    clear_inputs();

    // Saturation of the 4-bit stall counter
    do_reset();
    bus.dx_is_load = 1'b1; bus.dx_we = 1'b1; bus.dx_rd = 5'd12; bus.fd_rt = 5'd12; bus.fd_rt_used = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_count_14", 32'(bus.stall_count), 14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_count_15", 32'(bus.stall_count), 15);
    check("sat_stall_still", 32'(bus.stall), 1);
    clear_inputs();
    tick();
    check("sat_count_hold", 32'(bus.stall_count), 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
